// File: rtl/wb_chip_bus_pkg.sv
// Shared constants, decode payload and helpers for the wb_chip_bus backdoor interconnect.
package wb_chip_bus_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned MAX_SLV = 32;
    localparam int unsigned IDX_W   = 5;

    localparam logic [1:0] REGION_ROM  = 2'd0;
    localparam logic [1:0] REGION_RAM  = 2'd1;
    localparam logic [1:0] REGION_CSR  = 2'd2;
    localparam logic [1:0] REGION_NONE = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] CSR_ERR_COUNT = 2'd0;
    localparam logic [1:0] CSR_LAST_ERR  = 2'd1;
    localparam logic [1:0] CSR_CONFIG    = 2'd2;
    localparam logic [1:0] CSR_RSVD      = 2'd3;

    // Result of address decode: slave hit (valid & !is_csr), CSR hit, or unmapped (!valid)
    typedef struct packed {
        logic             valid;
        logic             is_csr;
        logic [IDX_W-1:0] idx;
    } decode_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/wb_chip_bus_decode.sv
// Combinational host-address decoder: region, select field range check and flat slave index.
module wb_chip_bus_decode
    import wb_chip_bus_pkg::*;
#(
    parameter int unsigned NUM_ROMS    = 1,
    parameter int unsigned NUM_RAMS    = 2,
    parameter int unsigned ROM_SEL_LSB = 10,
    parameter int unsigned RAM_SEL_LSB = 9
) (
    input  logic [ADDR_W-1:0] addr,
    output decode_t           dec_c
);

    logic [3:0] rom_sel;
    logic [3:0] ram_sel;
    logic       unused_addr;

    assign rom_sel     = addr[ROM_SEL_LSB +: 4];
    assign ram_sel     = addr[RAM_SEL_LSB +: 4];
    assign unused_addr = ^addr;

    always_comb begin
        dec_c = '0;
        case (addr[17:16])
            REGION_ROM: begin
                dec_c.valid = (32'(rom_sel) < NUM_ROMS);
                dec_c.idx   = IDX_W'(rom_sel);
            end
            REGION_RAM: begin
                dec_c.valid = (32'(ram_sel) < NUM_RAMS);
                dec_c.idx   = IDX_W'(NUM_ROMS) + IDX_W'(ram_sel);
            end
            REGION_CSR: begin
                dec_c.valid  = 1'b1;
                dec_c.is_csr = 1'b1;
            end
            default: dec_c = '0;
        endcase
    end

endmodule

// File: rtl/wb_chip_bus.sv
// Registered Wishbone backdoor interconnect: one outstanding transaction, error termination, CSR window.
// Optional busy-timeout termination is enabled by defining WB_CHIP_BUS_TIMEOUT_EN.
module wb_chip_bus
    import wb_chip_bus_pkg::*;
#(
    parameter int unsigned NUM_ROMS       = 1,
    parameter int unsigned NUM_RAMS       = 2,
    parameter int unsigned ROM_SEL_LSB    = 10,
    parameter int unsigned RAM_SEL_LSB    = 9,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [DATA_W-1:0]                    wb_data_i,
    input  logic [ADDR_W-1:0]                    wb_addr_i,
    input  logic                                 wb_cyc_i,
    input  logic                                 wb_strobe_i,
    input  logic                                 wb_we_i,
    output logic [DATA_W-1:0]                    wb_data_o,
    output logic                                 wb_ack_o,
    output logic                                 wb_err_o,
    output logic [DATA_W-1:0]                    s_data_o,
    output logic [ADDR_W-1:0]                    s_addr_o,
    output logic                                 s_we_o,
    output logic                                 s_cyc_o,
    output logic [NUM_ROMS+NUM_RAMS-1:0]         s_strobe_o,
    input  logic [DATA_W*(NUM_ROMS+NUM_RAMS)-1:0] s_data_i,
    input  logic [NUM_ROMS+NUM_RAMS-1:0]         s_ack_i
);

    localparam int unsigned NUM_SLV = NUM_ROMS + NUM_RAMS;
    localparam int unsigned PAD_W   = DATA_W * MAX_SLV;

    decode_t                dec_c;
    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       tgt_q, tgt_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]      last_err_q, last_err_d;
    logic [DATA_W-1:0]      rdata_d, sdata_d, csr_rdata;
    logic [ADDR_W-1:0]      saddr_d;
    logic                   ack_d, err_d, swe_d, scyc_d;
    logic [NUM_SLV-1:0]     sstb_d;
    logic [MAX_SLV-1:0]     ack_pad;
    logic [PAD_W-1:0]       data_pad;

    wb_chip_bus_decode #(
        .NUM_ROMS    (NUM_ROMS),
        .NUM_RAMS    (NUM_RAMS),
        .ROM_SEL_LSB (ROM_SEL_LSB),
        .RAM_SEL_LSB (RAM_SEL_LSB)
    ) u_decode (
        .addr  (wb_addr_i),
        .dec_c (dec_c)
    );

    // Zero-padded views so the latched target index selects with an exact-width index
    assign ack_pad  = MAX_SLV'(s_ack_i);
    assign data_pad = PAD_W'(s_data_i);

    always_comb begin
        case (wb_addr_i[3:2])
            CSR_ERR_COUNT: csr_rdata = DATA_W'(err_cnt_q);
            CSR_LAST_ERR:  csr_rdata = last_err_q;
            CSR_CONFIG:    csr_rdata = {16'h0000, 8'(NUM_RAMS), 8'(NUM_ROMS)};
            default:       csr_rdata = '0;
        endcase
    end

`ifdef WB_CHIP_BUS_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        rdata_d    = wb_data_o;
        saddr_d    = s_addr_o;
        sdata_d    = s_data_o;
        swe_d      = s_we_o;
        scyc_d     = s_cyc_o;
        sstb_d     = s_strobe_o;
        ack_d      = 1'b0;
        err_d      = 1'b0;
`ifdef WB_CHIP_BUS_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_strobe_i) begin
                    saddr_d = wb_addr_i;
                    sdata_d = wb_data_i;
                    swe_d   = wb_we_i;
                    tgt_d   = dec_c.idx;
                    if (dec_c.valid && !dec_c.is_csr) begin
                        state_d = ST_BUSY;
                        scyc_d  = 1'b1;
                        sstb_d  = NUM_SLV'(1) << dec_c.idx;
`ifdef WB_CHIP_BUS_TIMEOUT_EN
                        timer_d = '0;
`endif
                    end else if (dec_c.valid) begin
                        state_d = ST_DONE;
                        ack_d   = 1'b1;
                        rdata_d = csr_rdata;
                    end else begin
                        state_d    = ST_DONE;
                        err_d      = 1'b1;
                        rdata_d    = '0;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        last_err_d = wb_addr_i;
                    end
                end
            end
            ST_BUSY: begin
                // Host abandonment takes priority; the transaction vanishes without termination
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                    scyc_d  = 1'b0;
                    sstb_d  = '0;
                end else if (ack_pad[tgt_q]) begin
                    state_d = ST_DONE;
                    ack_d   = 1'b1;
                    rdata_d = data_pad[{tgt_q, 5'b00000} +: DATA_W];
                    scyc_d  = 1'b0;
                    sstb_d  = '0;
                end
`ifdef WB_CHIP_BUS_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_DONE;
                    err_d      = 1'b1;
                    rdata_d    = '0;
                    scyc_d     = 1'b0;
                    sstb_d     = '0;
                    err_cnt_d  = sat_inc(err_cnt_q);
                    last_err_d = s_addr_o;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tgt_q      <= '0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
            wb_data_o  <= '0;
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            s_addr_o   <= '0;
            s_data_o   <= '0;
            s_we_o     <= 1'b0;
            s_cyc_o    <= 1'b0;
            s_strobe_o <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
            wb_data_o  <= rdata_d;
            wb_ack_o   <= ack_d;
            wb_err_o   <= err_d;
            s_addr_o   <= saddr_d;
            s_data_o   <= sdata_d;
            s_we_o     <= swe_d;
            s_cyc_o    <= scyc_d;
            s_strobe_o <= sstb_d;
        end
    end

`ifdef WB_CHIP_BUS_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

endmodule

// File: tb/tb_wb_chip_bus.sv
// Randomized self-checking bench for wb_chip_bus against a transaction-level model of the bus rules.
module tb_wb_chip_bus;

    localparam int NR   = 1;
    localparam int NW   = 2;
    localparam int NS   = NR + NW;
    localparam int RLSB = 10;
    localparam int WLSB = 9;
    localparam int TMO  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   wb_data_i = '0, wb_addr_i = '0;
    logic          wb_cyc_i = 1'b0, wb_strobe_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0]   wb_data_o, s_data_o, s_addr_o;
    logic          wb_ack_o, wb_err_o, s_we_o, s_cyc_o;
    logic [NS-1:0] s_strobe_o;
    logic [32*NS-1:0] s_data_i = '0;
    logic [NS-1:0] s_ack_i = '0;

    always #5 clock = ~clock;

    wb_chip_bus #(
        .NUM_ROMS(NR), .NUM_RAMS(NW), .ROM_SEL_LSB(RLSB), .RAM_SEL_LSB(WLSB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_cyc_i(wb_cyc_i),
        .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i),
        .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .s_data_o(s_data_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
        .s_strobe_o(s_strobe_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
    );

    int checks = 0;
    int errors = 0;

    // Expected view of the outputs for the current cycle
    logic          chk_en = 1'b0, chk_data = 1'b0;
    logic          exp_ack = 1'b0, exp_err = 1'b0, exp_cyc = 1'b0, exp_swe = 1'b0;
    logic [NS-1:0] exp_stb = '0;
    logic [31:0]   exp_data = '0, exp_saddr = '0, exp_sdata = '0;

    int          model_errs = 0;
    logic [31:0] model_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("wb_ack", 32'(wb_ack_o), 32'(exp_ack));
            chk("wb_err", 32'(wb_err_o), 32'(exp_err));
            chk("s_cyc", 32'(s_cyc_o), 32'(exp_cyc));
            chk("s_strobe", 32'(s_strobe_o), 32'(exp_stb));
            if (chk_data) chk("wb_data", wb_data_o, exp_data);
            if (exp_cyc) begin
                chk("s_addr", s_addr_o, exp_saddr);
                chk("s_data", s_data_o, exp_sdata);
                chk("s_we", 32'(s_we_o), 32'(exp_swe));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        exp_ack = 1'b0; exp_err = 1'b0; exp_cyc = 1'b0; exp_stb = '0; chk_data = 1'b0;
    endtask

    task automatic drop_host();
        wb_cyc_i = 1'b0; wb_strobe_i = 1'b0;
    endtask

    // 0: slave k, 1: CSR, 2: unmapped
    function automatic int classify(input logic [31:0] a, output int k);
        int sel;
        k = 0;
        case (a[17:16])
            2'd0: begin
                sel = int'((a >> RLSB) & 32'hF);
                if (sel < NR) begin k = sel; return 0; end
                return 2;
            end
            2'd1: begin
                sel = int'((a >> WLSB) & 32'hF);
                if (sel < NW) begin k = NR + sel; return 0; end
                return 2;
            end
            2'd2: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] csr_value(input logic [31:0] a);
        case (a[3:2])
            2'd0: return 32'(model_errs);
            2'd1: return model_last;
            2'd2: return 32'((NW << 8) | NR);
            default: return 32'h0;
        endcase
    endfunction

    task automatic note_err(input logic [31:0] a);
        if (model_errs < 65535) model_errs++;
        model_last = a;
    endtask

    // One host transaction; lat = BUSY cycle in which the slave acks (-1 never), abort_at = BUSY cycle host drops cyc
    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [31:0] sd,
                          input int lat, input int abort_at, output logic [31:0] rd, output logic [NS-1:0] stb);
        int k, kind;
        logic [31:0] cv;
        kind = classify(a, k);
        rd = '0; stb = '0;
        wb_addr_i = a; wb_data_i = d; wb_we_i = we; wb_cyc_i = 1'b1; wb_strobe_i = 1'b1;
        if (kind != 0) begin
            cv = csr_value(a);
            step();
            exp_ack  = (kind == 1);
            exp_err  = (kind == 2);
            exp_data = (kind == 1) ? cv : 32'h0;
            chk_data = (kind == 2) || !we;
            if (kind == 2) note_err(a);
            rd = wb_data_o;
            drop_host();
            step();
            set_idle();
            return;
        end
        step();
        exp_cyc = 1'b1; exp_stb = NS'(1 << k); exp_saddr = a; exp_sdata = d; exp_swe = we;
        stb = s_strobe_o;
        for (int n = 0; n < 2000; n++) begin
            for (int j = 0; j < NS; j++) begin
                s_ack_i[j] = (j != k) && ($urandom_range(0, 3) == 0);
                s_data_i[32*j +: 32] = $urandom;
            end
            if (n == lat) begin
                s_ack_i[k] = 1'b1;
                s_data_i[32*k +: 32] = sd;
            end
            if (n == abort_at) drop_host();
            step();
            s_ack_i = '0;
            if (n == abort_at) begin
                set_idle();
                return;
            end
            if (n == lat) begin
                exp_ack = 1'b1; exp_cyc = 1'b0; exp_stb = '0; exp_data = sd; chk_data = !we;
                rd = wb_data_o;
                drop_host();
                step();
                set_idle();
                return;
            end
`ifdef WB_CHIP_BUS_TIMEOUT_EN
            if (n == TMO - 1) begin
                exp_err = 1'b1; exp_cyc = 1'b0; exp_stb = '0; exp_data = 32'h0; chk_data = 1'b1;
                note_err(a);
                rd = wb_data_o;
                drop_host();
                step();
                set_idle();
                return;
            end
`endif
        end
        checks++;
        errors++;
        $display("FAIL txn_bound actual=unterminated required=terminated at %0t", $time);
        drop_host();
        step();
        set_idle();
    endtask

    initial begin
        logic [31:0] rd, a;
        logic [NS-1:0] stb;
        int r, sel, lat, ab;

        set_idle();
        step();
        step();
        chk_en = 1'b1;
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_s_addr", s_addr_o, 32'h0);
        chk("rst_s_data", s_data_o, 32'h0);
        chk("rst_s_we", 32'(s_we_o), 32'h0);
        reset = 1'b1;
        step();

        // Two unmapped accesses, then the CSR window
        do_txn(32'h0003_0000, 32'h0, 1'b0, 32'h0, 0, -1, rd, stb);
        do_txn(32'h0000_1400, 32'h0, 1'b0, 32'h0, 0, -1, rd, stb);
        do_txn(32'h0002_0000, 32'h0, 1'b0, 32'h0, 0, -1, rd, stb);
        chk("csr0_literal", rd, 32'h0000_0002);
        do_txn(32'h0002_0004, 32'h0, 1'b0, 32'h0, 0, -1, rd, stb);
        chk("csr1_literal", rd, 32'h0000_1400);
        do_txn(32'h0002_0008, 32'h1234_5678, 1'b1, 32'h0, 0, -1, rd, stb);
        do_txn(32'h0002_0008, 32'h0, 1'b0, 32'h0, 0, -1, rd, stb);
        chk("csr2_literal", rd, 32'h0000_0201);

        // ROM0 read and RAM1 write
        do_txn(32'h0000_0004, 32'h0, 1'b0, 32'h0000_00A5, 1, -1, rd, stb);
        chk("rom0_read_literal", rd, 32'h0000_00A5);
        do_txn(32'h0001_0200, 32'hDEAD_BEEF, 1'b1, 32'h0, 0, -1, rd, stb);
        chk("ram1_strobe_literal", 32'(stb), 32'h0000_0004);

        // Abort in BUSY, then a late ack from the abandoned slave
        do_txn(32'h0001_0000, 32'h0, 1'b0, 32'h0, 5, 1, rd, stb);
        s_ack_i[1] = 1'b1;
        step();
        s_ack_i = '0;
        step();

        // Silent slave
`ifdef WB_CHIP_BUS_TIMEOUT_EN
        do_txn(32'h0000_0008, 32'h0, 1'b0, 32'h0, -1, -1, rd, stb);
        chk("timeout_data_literal", rd, 32'h0);
`else
        do_txn(32'h0000_0008, 32'h0, 1'b0, 32'h0, -1, 1000, rd, stb);
`endif

        // Reset asserted while BUSY
        wb_addr_i = 32'h0001_0000; wb_data_i = 32'h5555_AAAA; wb_we_i = 1'b0;
        wb_cyc_i = 1'b1; wb_strobe_i = 1'b1;
        step();
        exp_cyc = 1'b1; exp_stb = 3'b010; exp_saddr = wb_addr_i; exp_sdata = wb_data_i; exp_swe = 1'b0;
        step();
        reset = 1'b0;
        step();
        set_idle();
        model_errs = 0;
        model_last = '0;
        chk("midrst_wb_data", wb_data_o, 32'h0);
        chk("midrst_s_addr", s_addr_o, 32'h0);
        reset = 1'b1;
        drop_host();
        s_ack_i[1] = 1'b1;
        step();
        s_ack_i = '0;
        step();
        do_txn(32'h0001_0000, 32'h0, 1'b0, 32'hC0DE_0001, 0, -1, rd, stb);
        chk("post_rst_read_literal", rd, 32'hC0DE_0001);
        do_txn(32'h0002_0000, 32'h0, 1'b0, 32'h0, 0, -1, rd, stb);
        chk("post_rst_errcnt_literal", rd, 32'h0);

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            a = $urandom;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: begin a[17:16] = 2'd0; sel = $urandom_range(0, NR - 1); a[RLSB +: 4] = 4'(sel); end
                3, 4, 5: begin a[17:16] = 2'd1; sel = $urandom_range(0, NW - 1); a[WLSB +: 4] = 4'(sel); end
                6: begin a[17:16] = 2'd0; sel = $urandom_range(NR, 15); a[RLSB +: 4] = 4'(sel); end
                7: begin a[17:16] = 2'd1; sel = $urandom_range(NW, 15); a[WLSB +: 4] = 4'(sel); end
                8: a[17:16] = 2'd2;
                default: a[17:16] = 2'd3;
            endcase
`ifdef WB_CHIP_BUS_TIMEOUT_EN
            lat = $urandom_range(0, 6);
`else
            lat = $urandom_range(0, 5);
`endif
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat) : -1;
            do_txn(a, $urandom, 1'($urandom_range(0, 1)), $urandom, lat, ab, rd, stb);
            if ($urandom_range(0, 3) == 0) step();
        end

        do_txn(32'h0002_0000, 32'h0, 1'b0, 32'h0, 0, -1, rd, stb);
        do_txn(32'h0002_0004, 32'h0, 1'b0, 32'h0, 0, -1, rd, stb);
        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
